// File: rtl/alu_sequencer.sv
// Command sequencer in front of the 8-bit ALU datapath.
// Queues commands, issues them one at a time, returns results on valid/ready.
module alu_sequencer #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic         cmd_load,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [W-1:0] alu_result,
    output logic         alu_on,
    output logic [2:0]   in_sel,
    output logic [6:0]   out_sel,
    output logic [W-1:0] num1,
    output logic [W-1:0] num2,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic [2:0]   res_op,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    localparam logic [2:0] OP_CLR = 3'd7;

    localparam logic [2:0] SEL_RESET = 3'b001;
    localparam logic [2:0] SEL_LOAD  = 3'b010;

    typedef struct packed {
        logic [2:0]   op;
        logic         load;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        HOLD
    } state_t;

    state_t state;

    cmd_t fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    cmd_t         head;
    cmd_t         cmd_pkt;
    logic         push;
    logic         pop;
    logic         fifo_empty;

    logic [2:0]   cur_op;
    logic [W-1:0] acc;
    logic [W-1:0] cap_value;

    logic [2:0]   nxt_in_sel;
    logic [6:0]   nxt_out_sel;
    logic [W-1:0] nxt_num1;
    logic [W-1:0] nxt_num2;

    // FIFO handshake and pop decision
    always_comb begin
        cmd_pkt    = '{op: cmd_op, load: cmd_load, a: cmd_a, b: cmd_b};
        fifo_empty = (count == '0);
        cmd_ready  = (count != FULL);
        push       = cmd_valid && cmd_ready;
        head       = fifo_mem[rd_ptr];
        pop        = !fifo_empty &&
                     ((state == IDLE) ||
                      ((state == HOLD) && res_ready));
        busy       = (state != IDLE) || !fifo_empty;
    end

    // ALU drive values derived from the head command
    always_comb begin
        nxt_in_sel  = SEL_LOAD;
        nxt_out_sel = 7'b0000001 << head.op;
        nxt_num1    = head.load ? head.a : acc;
        nxt_num2    = head.b;
        if (head.op == OP_CLR) begin
            nxt_in_sel  = SEL_RESET;
            nxt_out_sel = '0;
            nxt_num1    = '0;
            nxt_num2    = '0;
        end
    end

    // Value captured from the ALU; CLR forces zero
    always_comb begin
        cap_value = (cur_op == OP_CLR) ? '0 : alu_result;
    end

    // FIFO storage, no reset needed for data
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_pkt;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sequencer FSM with registered ALU drives and result port
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cur_op    <= '0;
            alu_on    <= 1'b0;
            in_sel    <= SEL_RESET;
            out_sel   <= '0;
            num1      <= '0;
            num2      <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_op    <= '0;
        end else begin
            alu_on <= 1'b1;

            if (pop) begin
                in_sel  <= nxt_in_sel;
                out_sel <= nxt_out_sel;
                num1    <= nxt_num1;
                num2    <= nxt_num2;
                cur_op  <= head.op;
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    res_data  <= cap_value;
                    acc       <= cap_value;
                    res_op    <= cur_op;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= pop ? ISSUE : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
